// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from NUM_REQ byte streams,
// with per-requester frame lock and a start timeout on the transmitter handshake.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_lock,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_data_valid,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active,
    output logic                       timeout_err
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic                 tx_data_valid_q, tx_data_valid_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic                 lock_hold_q, lock_hold_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 active_q, active_d;
    logic                 timeout_err_q, timeout_err_d;

    logic                 win_found;
    logic [GW-1:0]        win_idx;
    logic [7:0]           win_data;
    logic                 win_lock;
    logic                 owner_valid;
    int unsigned          g;

    // Locked owner keeps the grant while valid; otherwise search upward from grant+1,
    // the current owner being the last candidate.
    always_comb begin
        win_found   = 1'b0;
        win_idx     = grant_q;
        win_data    = 8'h00;
        win_lock    = 1'b0;
        owner_valid = 1'b0;
        g           = 32'(grant_q);
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (GW'(j) == grant_q && req_valid[j]) owner_valid = 1'b1;
        end
        if (lock_hold_q && owner_valid) begin
            win_found = 1'b1;
        end else begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                for (int unsigned j = 0; j < NUM_REQ; j++) begin
                    if (!win_found && j == ((g + k) % NUM_REQ) && req_valid[j]) begin
                        win_found = 1'b1;
                        win_idx   = GW'(j);
                    end
                end
            end
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (GW'(j) == win_idx) begin
                win_data = req_data[8*j +: 8];
                win_lock = req_lock[j];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        req_ready_d     = '0;
        tx_data_valid_d = 1'b0;
        tx_data_d       = tx_data_q;
        grant_d         = grant_q;
        lock_hold_d     = lock_hold_q;
        cnt_d           = cnt_q;
        timeout_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found && !tx_busy) begin
                    for (int unsigned j = 0; j < NUM_REQ; j++) begin
                        if (GW'(j) == win_idx) req_ready_d[j] = 1'b1;
                    end
                    tx_data_d   = win_data;
                    grant_d     = win_idx;
                    lock_hold_d = win_lock;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                tx_data_valid_d = 1'b1;
                cnt_d           = '0;
                state_d         = WAIT_START;
            end
            WAIT_START: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    lock_hold_d   = 1'b0;
                    state_d       = IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            req_ready_q     <= '0;
            tx_data_valid_q <= 1'b0;
            tx_data_q       <= 8'h00;
            grant_q         <= GW'(NUM_REQ - 1);
            lock_hold_q     <= 1'b0;
            cnt_q           <= '0;
            active_q        <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            req_ready_q     <= req_ready_d;
            tx_data_valid_q <= tx_data_valid_d;
            tx_data_q       <= tx_data_d;
            grant_q         <= grant_d;
            lock_hold_q     <= lock_hold_d;
            cnt_q           <= cnt_d;
            active_q        <= active_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign tx_data_valid = tx_data_valid_q;
    assign tx_data       = tx_data_q;
    assign grant_id      = grant_q;
    assign active        = active_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter sharing a single `uart_transmitter` between `NUM_REQ` byte-stream requesters. It sits between client blocks (command responder, debug dumper, status reporter) and the transmitter's `tx_data_valid`/`tx_data`/`busy` port. It accepts one byte at a time from the winning requester and sequences it into the transmitter. A requester can hold ownership across a multi-byte frame, and a stalled transmitter is detected by a timeout.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `START_TIMEOUT`, 16: maximum clk cycles from `tx_data_valid` to observed `tx_busy`=1.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester byte available.
- `req_data`  in  8*NUM_REQ  byte of requester i is `req_data[8*i+7:8*i]`.
- `req_lock`  in  NUM_REQ  requester i keeps ownership after its current byte.
- `req_ready`  out  NUM_REQ  one-hot, one-cycle accept pulse; byte consumed when `req_valid[i]` & `req_ready[i]`.
- `tx_data_valid`  out  1  one-cycle start strobe to the transmitter.
- `tx_data`  out  8  byte to the transmitter; stable from strobe until back in IDLE.
- `tx_busy`  in  1  transmitter busy flag.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current or last owner.
- `active`  out  1  high in every state except IDLE.
- `timeout_err`  out  1  one-cycle pulse on start timeout.

## Operation
- States are IDLE, LOAD, WAIT_START and WAIT_DONE.
- IDLE:
  - If any `req_valid` and `tx_busy`=0, select a winner, then assert `req_ready[winner]`, capture `req_data` into `tx_data`, update `grant_id`, and go to LOAD.
  - Otherwise stay in IDLE with `req_ready`=0.
- Winner selection:
  - If `lock_hold`=1 and `req_valid[grant_id]`=1, the winner is `grant_id`.
  - Otherwise the winner is the first valid index searching upward from `grant_id`+1, wrapping modulo NUM_REQ.
  - If `lock_hold`=1 but the owner is not valid, the lock is dropped and round-robin applies.
- `lock_hold` is registered from `req_lock[winner]` at acceptance.
- LOAD: `tx_data_valid`=1 for exactly this cycle; clear the timeout counter; go to WAIT_START.
- WAIT_START:
  - If `tx_busy`=1, go to WAIT_DONE.
  - Otherwise increment the counter. When counter = START_TIMEOUT-1 with `tx_busy` still 0, pulse `timeout_err`, clear `lock_hold`, and go to IDLE. The byte is dropped.
- WAIT_DONE: when `tx_busy`=0, go to IDLE.
- `tx_busy` going high in LOAD is legal; WAIT_START then exits on its first cycle.
- Counter width is $clog2(START_TIMEOUT+1). It saturates and never wraps.
- `grant_id` wraps from NUM_REQ-1 to 0.

## Timing
- Reset values: state IDLE, `req_ready`=0, `tx_data_valid`=0, `tx_data`=8'h00, `grant_id`=NUM_REQ-1 (so requester 0 wins first), `lock_hold`=0, `active`=0, `timeout_err`=0, counter 0.
- Assertion of `rst` mid-transfer aborts immediately. No byte is replayed, and the transmitter finishes on its own.
- Accept-to-strobe latency: `req_ready` in cycle N, `tx_data_valid` in cycle N+1.
- All outputs are registered. `req_ready` never asserts outside IDLE and never toward a requester with `req_valid`=0.
- A requester must hold `req_valid`/`req_data` stable until accepted. Dropping `req_valid` before acceptance simply withdraws the request.
- Next acceptance occurs no earlier than 1 cycle after `tx_busy` falls (the IDLE evaluation cycle).
- Simultaneous `req_valid` on all inputs with no locks: grants rotate 0,1,2,3,0,… with one grant per byte.
- If `req_lock` changes while not accepted, it has no effect; it is sampled only at acceptance.
- If `tx_busy` rises in WAIT_START in the same cycle the counter would expire, `tx_busy` wins (no error).

## Test plan
- **Reset:** with all `req_valid` high during reset, check all outputs at reset values. After release, `req_ready`=4'b0001 within 1 cycle, then `tx_data_valid` next cycle with `tx_data`=`req_data[7:0]`. Use real `serial_clock_generator` + `uart_transmitter` at divider 8'h00.
- **Round-robin fairness:** all 4 requesters continuously valid with bytes 8'h11/8'h22/8'h33/8'h44 and no lock; capture 8 bytes on `sout` → 11,22,33,44,11,22,33,44.
- **Lock:** requester 2 sends 3 bytes 8'hA0,8'hA1,8'hA2 with `req_lock`=1 on the first two while requesters 0 and 1 are valid → `sout` shows A0,A1,A2 contiguously, then requester 3 is searched first (grant goes to 3 if valid, else wraps to 0).
- **Timeout:** tie `tx_busy`=0 (transmitter stubbed) → `timeout_err` pulses exactly START_TIMEOUT cycles after `tx_data_valid`, state returns to IDLE, and the next requester is granted.
- **Reset mid-byte:** assert `rst` in WAIT_DONE → outputs return to reset values in the same cycle. After release and `tx_busy` falling, requester 0 is granted first.
- **Busy at idle:** `tx_busy`=1 externally with `req_valid`=4'b1000 → no `req_ready` until `tx_busy`=0, then `req_ready`=4'b1000 in the following cycle.
